// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame constants and the receiver state encoding.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_r;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {2{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[0], d};
        end
    end

    assign q = sync_r[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 frame recovery into a valid/ready holding register.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

    uart_rx_state_e       state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 data_valid_r;
    logic                 framing_error_r;
    logic                 overrun_r;
    logic                 line_s;
    logic                 accept_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (rxd),
        .q      (line_s)
    );

    assign accept_s = data_valid_r && data_ready;

`ifdef UART_RX_PARITY_EN
    logic parity_error_r;
    logic par_err_r;
`endif

    // Frame FSM, holding register and status flags; frame state moves only on sample ticks
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            bit_idx_r       <= '0;
            shift_r         <= '0;
            data_out_r      <= '0;
            data_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r  <= 1'b0;
            par_err_r       <= 1'b0;
`endif
        end else begin
            framing_error_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r  <= 1'b0;
`endif
            if (accept_s) begin
                data_valid_r <= 1'b0;
            end
            if (overrun_clr) begin
                overrun_r <= 1'b0;
            end
            if (sample_tick) begin
                case (state_r)
                    IDLE: begin
                        if (!line_s) begin
                            state_r <= START;
                            cnt_r   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_r == HALF_LAST) begin
                            cnt_r     <= '0;
                            bit_idx_r <= '0;
                            state_r   <= line_s ? IDLE : DATA;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (cnt_r == BIT_LAST) begin
                            cnt_r   <= '0;
                            // LSB arrives first, so after DATA_BITS shifts it sits in bit 0
                            shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
                            if (bit_idx_r == IDX_LAST) begin
                                bit_idx_r <= '0;
`ifdef UART_RX_PARITY_EN
                                state_r   <= PARITY;
`else
                                state_r   <= STOP;
`endif
                            end else begin
                                bit_idx_r <= bit_idx_r + IDX_ONE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt_r == BIT_LAST) begin
                            cnt_r     <= '0;
                            par_err_r <= line_s ^ even_parity(shift_r);
                            state_r   <= STOP;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
`endif
                    STOP: begin
                        // Return to IDLE at mid stop bit so the next falling edge is caught early
                        if (cnt_r == BIT_LAST) begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                            if (!line_s) begin
                                framing_error_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_err_r) begin
                                parity_error_r <= 1'b1;
`endif
                            end else if (!data_valid_r || accept_s) begin
                                data_out_r   <= shift_r;
                                data_valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out      = data_out_r;
    assign data_valid    = data_valid_r;
    assign framing_error = framing_error_r;
    assign overrun       = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_r;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of whole frames plus hand-written corner sequences.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS   = UART_OVERSAMPLE;
    localparam int TDIV = 4;
    localparam int BITC = OS * TDIV;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       sample_tick;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       framing_error;
    logic       parity_error;
    logic       overrun;
    logic       overrun_clr;
    logic [1:0] div_r = 2'd0;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_bad;
        int         exp_rx;
        logic [7:0] exp_byte;
        int         exp_fe;
        int         exp_pe;
    } vec_t;

    vec_t vecs[8];
    int   n_vec;

    uart_rx dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .rxd           (rxd),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) div_r <= div_r + 2'd1;
    assign sample_tick = (div_r == 2'd3);

    // Observe handshakes and error pulses away from the active edge
    always @(negedge clk_in) begin
        if (data_valid && data_ready) begin
            rx_cnt  = rx_cnt + 1;
            last_rx = data_out;
        end
        if (framing_error) fe_cnt = fe_cnt + 1;
        if (parity_error)  pe_cnt = pe_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        step(BITC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_bad);
`endif
        send_bit(stop_bit);
        rxd = 1'b1;
        step(2 * BITC);
    endtask

    initial begin
        int r0, f0, p0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1, 0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1, 8'h11, 0, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1, 8'h80, 0, 0};
        n_vec = 6;
`ifdef UART_RX_PARITY_EN
        vecs[6] = '{8'h07, 1'b1, 1'b1, 0, 8'h00, 0, 1};
        vecs[7] = '{8'h07, 1'b1, 1'b0, 1, 8'h07, 0, 0};
        n_vec = 8;
`endif

        rst_n       = 1'b0;
        rxd         = 1'b1;
        data_ready  = 1'b1;
        overrun_clr = 1'b0;
        #1;
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_fe", 32'(framing_error), 32'h0);
        check("reset_pe", 32'(parity_error), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        step(5);
        rst_n = 1'b1;
        step(4 * TDIV);

        for (int v = 0; v < n_vec; v++) begin
            r0 = rx_cnt; f0 = fe_cnt; p0 = pe_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].par_bad);
            check($sformatf("vec%0d_rx_count", v), 32'(rx_cnt - r0), 32'(vecs[v].exp_rx));
            if (vecs[v].exp_rx != 0)
                check($sformatf("vec%0d_byte", v), 32'(last_rx), 32'(vecs[v].exp_byte));
            check($sformatf("vec%0d_fe", v), 32'(fe_cnt - f0), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_pe", v), 32'(pe_cnt - p0), 32'(vecs[v].exp_pe));
            check($sformatf("vec%0d_valid_cleared", v), 32'(data_valid), 32'h0);
        end

        // Short low glitch must be rejected at mid start bit
        r0 = rx_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        step(5 * TDIV);
        rxd = 1'b1;
        step(2 * BITC);
        check("glitch_rx", 32'(rx_cnt - r0), 32'h0);
        check("glitch_fe", 32'(fe_cnt - f0), 32'h0);
        check("glitch_state", 32'(dut.state_r), 32'(IDLE));

        // Overrun: second byte arrives while the first is still held
        data_ready = 1'b0;
        r0 = rx_cnt;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_data_kept", 32'(data_out), 32'h01);
        check("ovr_flag", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        data_ready = 1'b1;
        step(1);
        check("ovr_accept_valid", 32'(data_valid), 32'h0);
        check("ovr_accept_count", 32'(rx_cnt - r0), 32'h1);
        check("ovr_accept_byte", 32'(last_rx), 32'h01);

        // Reset during the 4th data bit with non-zero outputs pending
        data_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0);
        check("pre_rst_data", 32'(data_out), 32'hC3);
        check("pre_rst_overrun", 32'(overrun), 32'h1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rxd = 1'b1;
        step(BITC / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        check("midrst_fe", 32'(framing_error), 32'h0);
        check("midrst_pe", 32'(parity_error), 32'h0);
        step(4);
        rst_n = 1'b1;
        data_ready = 1'b1;
        step(2 * BITC);
        check("post_rst_state", 32'(dut.state_r), 32'(IDLE));
        r0 = rx_cnt; f0 = fe_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post_rst_rx", 32'(rx_cnt - r0), 32'h1);
        check("post_rst_byte", 32'(last_rx), 32'h5A);
        check("post_rst_fe", 32'(fe_cnt - f0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous UART receiver: recovers 8N1 frames (optionally 8E1) from a serial line and presents each byte on a valid/ready holding register.
- Runs in the system clock domain.
- Times bits from a one-cycle `sample_tick` enable at OVERSAMPLE × baud, produced by the UART's sample-clock divider logic; it does not use a divided clock.
- Receive-side counterpart to the UART transmit path.

## Interface
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk_in` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sample_tick` input 1: one-cycle enable at OVERSAMPLE × baud.
- `rxd` input 1: serial line, asynchronous; idles high.
- `data_out` output DATA_BITS: received byte; stable while `data_valid`=1.
- `data_valid` output 1: byte available.
- `data_ready` input 1: consumer accepts byte when `data_valid && data_ready`.
- `framing_error` output 1: one-cycle pulse, stop bit sampled low.
- `parity_error` output 1: one-cycle pulse, parity mismatch (see Configuration).
- `overrun` output 1: sticky; byte lost because the holding register was full.
- `overrun_clr` input 1: clears `overrun`.

## Operation
- `rxd` passes through a two-flop synchronizer, reset value 1. All references to "line" below mean the synchronized value.
- All state advances only on cycles where `sample_tick`=1. `data_ready` handshakes and `overrun_clr` act on any cycle.
- **IDLE**
  - On a tick with line=0: go to START and load the tick counter with 0.
- **START**
  - On the tick where the counter reaches OVERSAMPLE/2−1 (mid start bit):
    - line=1 → false start, return to IDLE with no outputs.
    - line=0 → go to DATA, reset counter and bit index.
- **DATA**
  - Every OVERSAMPLE ticks, sample line into shift register bit [index], LSB first.
  - After bit DATA_BITS−1: go to PARITY if the feature is compiled in, else STOP.
- **PARITY**
  - Sample after OVERSAMPLE ticks.
  - Compare against even parity of the data bits; the mismatch is held until stop.
- **STOP**
  - Sample after OVERSAMPLE ticks (mid stop bit), then return to IDLE on the same tick. This resyncs on the next falling edge with no wait for the end of the stop bit.
  - Stop=0: pulse `framing_error`; discard the byte.
  - Parity mismatch: pulse `parity_error`; discard the byte.
  - Otherwise, holding register empty: load `data_out`, set `data_valid`.
  - Otherwise, holding register full (`data_valid`=1 and not being accepted this cycle): keep the old byte, drop the new one, set `overrun`.
- Accept and load in the same cycle: the new byte loads and `data_valid` stays 1. This is not an overrun.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- Line stuck low after a framing error: IDLE re-enters START on the next tick. Each 0-frame yields another `framing_error`.
- Tick counter width is $clog2(OVERSAMPLE); bit index width is $clog2(DATA_BITS+1). Counters wrap to 0 on each bit boundary.

## Timing
- Reset values:
  - state IDLE, counters 0, synchronizer 1.
  - `data_out`=0, `data_valid`=0, `framing_error`=0, `parity_error`=0, `overrun`=0.
- `rst_n` asserted mid-frame: immediate return to IDLE with all outputs at reset values. The partial byte is lost.
- Synchronizer latency: 2 `clk_in` cycles.
- `data_valid`, `framing_error` and `parity_error` register one `clk_in` cycle after the tick that samples the stop bit.
- Frame-to-valid latency: (DATA_BITS + 1 + parity) × OVERSAMPLE + OVERSAMPLE/2 ticks from the detected falling edge, ±1 tick of edge quantization.
- `data_valid` clears the cycle after acceptance when no new byte loads.
- No combinational path from inputs to outputs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state exists.
  - One even-parity bit is expected between data and stop.
  - `parity_error` is functional.
- Undefined:
  - PARITY state and its logic are absent.
  - Frame is start + DATA_BITS + stop.
  - `parity_error` is tied 0.

## Structure
- Package `uart_pkg`:
  - state enum `uart_rx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8, shared with the transmitter and divider.
- Sub-module `sync_2ff`: two-flop synchronizer with asynchronous active-low reset and a reset-value parameter. Instantiated once for `rxd`.

## Test plan
- Byte 0xA5, OVERSAMPLE=16, `data_ready`=1 → one `data_valid` pulse with `data_out`=0xA5, no error flags.
- Low glitch of 5 ticks on idle line → no `data_valid`, no errors, state back to IDLE.
- Frame 0x3C with stop bit driven low → `framing_error` pulses once, `data_valid` stays 0. The next frame 0x11 is received correctly.
- Bytes 0x01 then 0x02 back to back with `data_ready`=0 → `data_out`=0x01 retained and `overrun`=1. `overrun_clr` clears it; accepting 0x01 drops `data_valid`.
- `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 → `parity_error` pulse, no valid. The same byte with parity 1 → valid 0x07.
- `rst_n` asserted during the 4th data bit → all outputs 0 immediately. The frame after release is received correctly.
